pipe_reg_chain: RTL and testbench
=================================

// Module: pipe_reg_chain
// PURPOSE
//  Parametrised chain of DEPTH pipeline registers, each WIDTH data bits plus a valid bit.
//  Per-stage stall and flush control, with automatic bubble insertion below a stall point.
//  Replaces hand-wired chains of enable/clear flops between pipeline stages of the MIPS datapath.
//  Driven by the hazard unit (StallF/StallD/FlushE style controls).
// PARAMETERS
//  WIDTH  32  data bits carried per stage (>=1)
//  DEPTH  4   number of register stages (>=1); stage 0 is fed from the input, stage DEPTH-1 drives the output
// PORTS
//  clk          in   1            rising-edge clock
//  reset        in   1            asynchronous, active-high reset
//  in_valid     in   1            input token present
//  in_data      in   WIDTH        input payload
//  stall        in   DEPTH        stall[i]=1 holds stage i and all stages upstream of it
//  flush        in   DEPTH        flush[i]=1 clears stage i on the next edge
//  in_ready     out  1            stage 0 will load this cycle (= ~|stall)
//  out_valid    out  1            valid of stage DEPTH-1
//  out_data     out  WIDTH        data of stage DEPTH-1
//  stage_valid  out  DEPTH        valid bit of every stage
//  stage_data   out  DEPTH*WIDTH  flattened stage data; stage i at [i*WIDTH +: WIDTH]
//  occ          out  $clog2(DEPTH+1)  count of valid stages (PIPE_OCC_CNT_EN only)
// BEHAVIOUR
//  - Reset (async): all valid bits=0, all data=0, occ=0. Reset is legal mid-stream; in-flight tokens are discarded.
//  - hold_i = |stall[DEPTH-1:i]. A stall propagates upstream, never downstream.
//  - Per-stage update priority at each posedge: reset > flush[i] > hold_i > advance.
//    - flush: valid_i<=0, data_i<=0. Flush overrides stall on the same stage.
//    - hold: valid_i and data_i keep their values.
//    - advance: src = (i==0) ? {in_valid,in_data} : {valid_(i-1),data_(i-1)}.
//      If i>0 and hold_(i-1)=1 (upstream held), insert a bubble: valid_i<=0, data_i<=0.
//      Else valid_i<=src.valid; data_i<=src.valid ? src.data : 0. Invalid slots always carry zero data.
//  - A flush of stage i-1 does not affect what stage i samples on that edge; stage i takes the registered value.
//  - flush[0] with in_valid=1 and no stall: the token is accepted (in_ready=1) and then dropped.
//  - in_ready is combinational from stall only; it does not depend on in_valid or flush.
//  - Latency: DEPTH cycles from in_valid sampled to out_valid with no stall/flush. Throughput: 1 token/cycle.
//  - No combinational path from in_* to out_*. All outputs are registered except in_ready.
//  - DEPTH=1: stall[0] holds the only stage; bubble insertion does not apply.
// CONFIGURATION
//  - PIPE_OCC_CNT_EN defined: occ port is present and is a registered count of valid stages.
//    Updated each edge to popcount of the next valid bits; 0 on reset; never exceeds DEPTH.
//  - Not defined: occ port and its counter are absent; all other behaviour is identical.
// TESTING (WIDTH=8, DEPTH=4 unless noted)
//  1. Stream 0x11,0x22,0x33 on cycles 0-2, no stall -> out_valid=1 with out_data 0x11/0x22/0x33 on cycles 4/5/6.
//     out_valid=0 and out_data=0x00 otherwise.
//  2. Pipe full (A,B,C,D in stages 0..3), stall=4'b0010 for 1 cycle, in_valid=1 with E.
//     -> in_ready=0; stages 0,1 keep A,B; stage 2 becomes a bubble (0,0x00); stage 3 takes C.
//     -> Next cycle, with no stall, E enters and no token is lost.
//  3. stall[2] and flush[2] together, pipe full -> stage 2 cleared; stages 0,1 hold; stage 3 takes the bubble.
//  4. flush[0]=1, in_valid=1, in_data=0x5A, no stall -> in_ready=1; stage 0 = (0,0x00); 0x5A never appears at out.
//  5. Assert reset asynchronously mid-cycle with the pipe full -> all stage_valid=0 and data=0 immediately.
//     -> Stream resumes cleanly 1 cycle after release.
//  6. With PIPE_OCC_CNT_EN: fill 4 tokens -> occ=4; flush=4'b1000 -> occ=3 next cycle; reset -> occ=0.
//     Repeat with DEPTH=1 and WIDTH=32 to check the boundaries.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// Chain of DEPTH valid+data registers with per-stage stall/flush; DEPTH-cycle latency, 1 token/cycle.
// A stall holds its stage and all upstream stages and drops a bubble just below; PIPE_OCC_CNT_EN adds the occ counter.
module pipe_reg_chain #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [DEPTH-1:0]         stall,
   input  logic [DEPTH-1:0]         flush,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic [DEPTH-1:0]         stage_valid,
   output logic [DEPTH*WIDTH-1:0]   stage_data
`ifdef PIPE_OCC_CNT_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

   logic [DEPTH-1:0]            hold;
   logic [DEPTH-1:0]            valid_q;
   logic [DEPTH-1:0][WIDTH-1:0] data_q;
`ifdef PIPE_OCC_CNT_EN
   logic [DEPTH-1:0]            valid_nxt;
`endif

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic             src_valid;
      logic [WIDTH-1:0] src_data;
      logic             up_hold;
      logic             v_q, v_nxt;
      logic [WIDTH-1:0] d_q, d_nxt;

      // A stall anywhere downstream freezes this stage too.
      assign hold[g] = |stall[DEPTH-1:g];

      if (g == 0) begin : g_head
         assign src_valid = in_valid;
         assign src_data  = in_data;
         assign up_hold   = 1'b0;
      end else begin : g_body
         assign src_valid = valid_q[g-1];
         assign src_data  = data_q[g-1];
         assign up_hold   = hold[g-1];
      end

      always_comb begin
         v_nxt = v_q;
         d_nxt = d_q;
         if (flush[g]) begin
            v_nxt = 1'b0;
            d_nxt = '0;
         end else if (!hold[g]) begin
            if (up_hold) begin
               v_nxt = 1'b0;
               d_nxt = '0;
            end else begin
               v_nxt = src_valid;
               d_nxt = src_valid ? src_data : '0;
            end
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            v_q <= 1'b0;
            d_q <= '0;
         end else begin
            v_q <= v_nxt;
            d_q <= d_nxt;
         end
      end

      assign valid_q[g] = v_q;
      assign data_q[g]  = d_q;
`ifdef PIPE_OCC_CNT_EN
      assign valid_nxt[g] = v_nxt;
`endif
   end

   assign in_ready    = ~|stall;
   assign out_valid   = valid_q[DEPTH-1];
   assign out_data    = data_q[DEPTH-1];
   assign stage_valid = valid_q;
   assign stage_data  = data_q;

`ifdef PIPE_OCC_CNT_EN
   localparam int OCC_W = $clog2(DEPTH+1);
   logic [OCC_W-1:0] occ_nxt;

   // Count the bits about to be loaded so occ tracks stage_valid cycle for cycle.
   always_comb begin
      occ_nxt = '0;
      for (int i = 0; i < DEPTH; i++) occ_nxt = occ_nxt + OCC_W'(valid_nxt[i]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) occ <= '0;
      else       occ <= occ_nxt;
   end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Randomised and directed bench for pipe_reg_chain (8x4 instance plus a 32x1 boundary instance).
module tb_pipe_reg_chain;
   localparam int W = 8;
   localparam int D = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic           in_valid = 1'b0;
   logic [W-1:0]   in_data = '0;
   logic [D-1:0]   stall = '0;
   logic [D-1:0]   flush = '0;
   logic           in_ready, out_valid;
   logic [W-1:0]   out_data;
   logic [D-1:0]   stage_valid;
   logic [D*W-1:0] stage_data;

   logic           b_in_valid = 1'b0;
   logic [31:0]    b_in_data = '0;
   logic [0:0]     b_stall = '0;
   logic [0:0]     b_flush = '0;
   logic           b_in_ready, b_out_valid;
   logic [31:0]    b_out_data;
   logic [0:0]     b_stage_valid;
   logic [31:0]    b_stage_data;
`ifdef PIPE_OCC_CNT_EN
   logic [2:0]     occ;
   logic [0:0]     b_occ;
`endif

   pipe_reg_chain #(.WIDTH(W), .DEPTH(D)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .stall(stall), .flush(flush), .in_ready(in_ready), .out_valid(out_valid),
      .out_data(out_data), .stage_valid(stage_valid), .stage_data(stage_data)
`ifdef PIPE_OCC_CNT_EN
      , .occ(occ)
`endif
   );

   pipe_reg_chain #(.WIDTH(32), .DEPTH(1)) u_dut1 (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data(b_in_data),
      .stall(b_stall), .flush(b_flush), .in_ready(b_in_ready), .out_valid(b_out_valid),
      .out_data(b_out_data), .stage_valid(b_stage_valid), .stage_data(b_stage_data)
`ifdef PIPE_OCC_CNT_EN
      , .occ(b_occ)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: what each stage holds, as plain arrays.
   logic         mv[D];
   logic [W-1:0] md[D];
   logic         bv;
   logic [31:0]  bd;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < D; i++) begin mv[i] = 1'b0; md[i] = '0; end
      bv = 1'b0;
      bd = '0;
   endtask

   // Everything at or above the topmost stalled stage freezes, the stage just below it
   // receives a bubble, the rest shift by one; flushed stages then read empty.
   task automatic model_step(input logic iv, input logic [W-1:0] id,
                             input logic [D-1:0] st, input logic [D-1:0] fl);
      logic         nv[D];
      logic [W-1:0] nd[D];
      int top = -1;
      for (int i = 0; i < D; i++) if (st[i]) top = i;
      for (int i = 0; i < D; i++) begin
         if (i <= top) begin
            nv[i] = mv[i]; nd[i] = md[i];
         end else if (i == 0) begin
            nv[i] = iv; nd[i] = iv ? id : '0;
         end else if (i - 1 <= top) begin
            nv[i] = 1'b0; nd[i] = '0;
         end else begin
            nv[i] = mv[i-1]; nd[i] = md[i-1];
         end
         if (fl[i]) begin nv[i] = 1'b0; nd[i] = '0; end
      end
      for (int i = 0; i < D; i++) begin mv[i] = nv[i]; md[i] = nd[i]; end
      if (b_flush[0]) begin
         bv = 1'b0; bd = '0;
      end else if (!b_stall[0]) begin
         bv = b_in_valid; bd = b_in_valid ? b_in_data : '0;
      end
   endtask

   task automatic check_all();
      logic [D*W-1:0] ev;
      logic [D-1:0]   evv;
      int cnt = 0;
      for (int i = 0; i < D; i++) begin
         ev[i*W +: W] = md[i];
         evv[i] = mv[i];
         cnt += int'(mv[i]);
      end
      check("stage_valid", 64'(stage_valid), 64'(evv));
      check("stage_data",  64'(stage_data),  64'(ev));
      check("out_valid",   64'(out_valid),   64'(mv[D-1]));
      check("out_data",    64'(out_data),    64'(md[D-1]));
      check("d1_valid",    64'(b_out_valid), 64'(bv));
      check("d1_data",     64'(b_out_data),  64'(bd));
      check("d1_stage",    64'(b_stage_data), 64'(bd));
`ifdef PIPE_OCC_CNT_EN
      check("occ",         64'(occ),   64'(cnt));
      check("d1_occ",      64'(b_occ), 64'(bv));
`endif
   endtask

   // Entered just after a falling edge; leaves just after the next falling edge.
   task automatic cycle(input logic iv, input logic [W-1:0] id,
                        input logic [D-1:0] st, input logic [D-1:0] fl);
      in_valid = iv; in_data = id; stall = st; flush = fl;
      b_in_valid = 1'($urandom_range(0, 1));
      b_in_data  = $urandom;
      b_stall    = 1'($urandom_range(0, 3) == 0);
      b_flush    = 1'($urandom_range(0, 5) == 0);
      #1;
      check("in_ready",    64'(in_ready),   64'(st == '0));
      check("d1_in_ready", 64'(b_in_ready), 64'(!b_stall[0]));
      @(posedge clk);
      model_step(iv, id, st, fl);
      @(negedge clk);
      #1;
      check_all();
   endtask

   task automatic async_reset();
      #2 reset = 1'b1;
      #1;
      model_clear();
      check_all();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_all();
   endtask

   task automatic fill(input logic [W-1:0] base);
      for (int i = 0; i < D; i++) cycle(1'b1, base + W'(i), '0, '0);
   endtask

   initial begin
      model_clear();
      @(negedge clk);
      #1 check_all();
      @(negedge clk);
      reset = 1'b0;
      #1;

      // Three back-to-back tokens emerge after DEPTH edges.
      cycle(1'b1, 8'h11, '0, '0);
      cycle(1'b1, 8'h22, '0, '0);
      cycle(1'b1, 8'h33, '0, '0);
      cycle(1'b0, 8'h00, '0, '0);
      check("t1_out0", 64'(out_data), 64'h11);
      cycle(1'b0, 8'h00, '0, '0);
      check("t1_out1", 64'(out_data), 64'h22);
      cycle(1'b0, 8'h00, '0, '0);
      check("t1_out2", 64'(out_data), 64'h33);
      cycle(1'b0, 8'hFF, '0, '0);
      check("t1_out3", 64'(out_valid), 64'h0);

      // Mid-chain stall: bubble below it, nothing lost afterwards.
      cycle(1'b1, 8'hD4, '0, '0);
      cycle(1'b1, 8'hC3, '0, '0);
      cycle(1'b1, 8'hB2, '0, '0);
      cycle(1'b1, 8'hA1, '0, '0);
      cycle(1'b1, 8'hE5, 4'b0010, '0);
      check("t2_stall_data",  64'(stage_data),  64'hC300B2A1);
      check("t2_stall_valid", 64'(stage_valid), 64'b1011);
      cycle(1'b1, 8'hE5, '0, '0);
      check("t2_resume_data", 64'(stage_data),  64'h00B2A1E5);

      // Stall and flush on the same stage.
      fill(8'h40);
      cycle(1'b0, 8'h00, 4'b0100, 4'b0100);
      check("t3_valid", 64'(stage_valid), 64'b0011);

      // Accepted-then-dropped token at the head.
      cycle(1'b1, 8'h5A, '0, 4'b0001);
      check("t4_head", 64'(stage_valid[0]), 64'h0);
      for (int i = 0; i < D; i++) cycle(1'b0, 8'($urandom), '0, '0);

      // Asynchronous reset with a full pipe, then a clean restart.
      fill(8'h70);
      async_reset();
      cycle(1'b1, 8'h77, '0, '0);
      check("t5_restart", 64'(stage_valid), 64'b0001);

`ifdef PIPE_OCC_CNT_EN
      fill(8'h90);
      check("t6_full", 64'(occ), 64'd4);
      cycle(1'b1, 8'h99, '0, 4'b1000);
      check("t6_flush", 64'(occ), 64'd3);
      async_reset();
      check("t6_reset", 64'(occ), 64'd0);
`endif

      for (int n = 0; n < 600; n++) begin
         logic [D-1:0] st, fl;
         st = ($urandom_range(0, 3) == 0) ? D'($urandom) : '0;
         fl = ($urandom_range(0, 5) == 0) ? D'($urandom) : '0;
         if ($urandom_range(0, 99) == 0) async_reset();
         else cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), st, fl);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
